// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer shared types: FSM states, next-PC sources and defaults.
// Optional alignment checking is enabled with PC_ALIGN_CHK_EN.
package pc_pkg;

  typedef enum logic {
    S_RESET,
    S_RUN
  } state_t;

  typedef enum logic [2:0] {
    SRC_EXC,
    SRC_ERET,
    SRC_BR,
    SRC_JMP,
    SRC_HOLD,
    SRC_SEQ
  } src_t;

  localparam logic [31:0] EXC_VEC_DEF = 32'h0000_0180;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the pipeline and the PC sequencer.
// The misalign flag exists only when PC_ALIGN_CHK_EN is defined.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              hold_pc;
  logic              jump_valid;
  logic [ADDR_W-1:0] jump_target;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              exc_valid;
  logic [ADDR_W-1:0] exc_pc;
  logic              eret_valid;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus_inc;
  logic              pc_valid;
  logic [ADDR_W-1:0] epc;
  logic              redirect;
`ifdef PC_ALIGN_CHK_EN
  logic              misalign;
`endif

  modport master (
    output hold_pc, jump_valid, jump_target,
    output branch_taken, branch_target,
    output exc_valid, exc_pc, eret_valid,
    input  pc, pc_plus_inc, pc_valid,
`ifdef PC_ALIGN_CHK_EN
    input  misalign,
`endif
    input  epc, redirect
  );

  modport slave (
    input  hold_pc, jump_valid, jump_target,
    input  branch_taken, branch_target,
    input  exc_valid, exc_pc, eret_valid,
    output pc, pc_plus_inc, pc_valid,
`ifdef PC_ALIGN_CHK_EN
    output misalign,
`endif
    output epc, redirect
  );

endinterface

// File: rtl/pc_sequencer_next_sel.sv
// Next-PC priority encoder: picks the source and the candidate PC.
// Pure combinational; registers and alignment checks live in the top.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INC    = 4,
  parameter logic [ADDR_W-1:0] EXC_PC = '0
) (
  input  logic              i_exc,
  input  logic              i_eret,
  input  logic              i_br,
  input  logic              i_jmp,
  input  logic              i_hold,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_epc,
  input  logic [ADDR_W-1:0] i_br_tgt,
  input  logic [ADDR_W-1:0] i_jmp_tgt,
  output src_t              o_src,
  output logic [ADDR_W-1:0] o_pc
);

  // Highest-priority active request selects the next PC.
  always_comb begin
    o_src = SRC_SEQ;
    o_pc  = i_pc + ADDR_W'(INC);
    priority case (1'b1)
      i_exc: begin
        o_src = SRC_EXC;
        o_pc  = EXC_PC;
      end
      i_eret: begin
        o_src = SRC_ERET;
        o_pc  = i_epc;
      end
      i_br: begin
        o_src = SRC_BR;
        o_pc  = i_br_tgt;
      end
      i_jmp: begin
        o_src = SRC_JMP;
        o_pc  = i_jmp_tgt;
      end
      i_hold: begin
        o_src = SRC_HOLD;
        o_pc  = i_pc;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register, EPC and reset/run FSM at the head of IF.
// Define PC_ALIGN_CHK_EN to trap misaligned branch/jump/eret targets.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF,
  parameter int INC = 4
) (
  input logic         clk,
  input logic         reset,
  pc_sequencer_if.slave bus
);

  localparam logic [ADDR_W-1:0] W_EXC = ADDR_W'(EXC_VEC);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_epc;
  logic [ADDR_W-1:0] w_epc_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              r_redir;
  logic              w_redir_nxt;
  src_t              w_sel_src;
  logic [ADDR_W-1:0] w_sel_pc;
`ifdef PC_ALIGN_CHK_EN
  logic              r_mis;
  logic              w_mis_nxt;
`endif

  pc_next_sel #(
    .ADDR_W (ADDR_W),
    .INC    (INC),
    .EXC_PC (W_EXC)
  ) u_sel (
    .i_exc     (bus.exc_valid),
    .i_eret    (bus.eret_valid),
    .i_br      (bus.branch_taken),
    .i_jmp     (bus.jump_valid),
    .i_hold    (bus.hold_pc),
    .i_pc      (r_pc),
    .i_epc     (r_epc),
    .i_br_tgt  (bus.branch_target),
    .i_jmp_tgt (bus.jump_target),
    .o_src     (w_sel_src),
    .o_pc      (w_sel_pc)
  );

  // Next-state logic: release edge only arms fetch, run applies selection.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    w_valid_nxt = r_valid;
    w_redir_nxt = 1'b0;
`ifdef PC_ALIGN_CHK_EN
    w_mis_nxt   = 1'b0;
`endif
    unique case (r_state)
      S_RESET: begin
        w_state_nxt = S_RUN;
        w_pc_nxt    = RESET_VEC;
        w_valid_nxt = 1'b1;
      end
      S_RUN: begin
        w_pc_nxt    = w_sel_pc;
        w_redir_nxt = (w_sel_src != SRC_HOLD) &&
                      (w_sel_src != SRC_SEQ);
        if (w_sel_src == SRC_EXC) begin
          w_epc_nxt = bus.exc_pc;
        end
`ifdef PC_ALIGN_CHK_EN
        if (w_redir_nxt && (w_sel_src != SRC_EXC) &&
            (w_sel_pc[1:0] != 2'b00)) begin
          w_pc_nxt  = W_EXC;
          w_epc_nxt = w_sel_pc;
          w_mis_nxt = 1'b1;
        end
`endif
      end
      default: w_state_nxt = S_RESET;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RESET;
      r_pc    <= RESET_VEC;
      r_epc   <= '0;
      r_valid <= 1'b0;
      r_redir <= 1'b0;
`ifdef PC_ALIGN_CHK_EN
      r_mis   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_epc   <= w_epc_nxt;
      r_valid <= w_valid_nxt;
      r_redir <= w_redir_nxt;
`ifdef PC_ALIGN_CHK_EN
      r_mis   <= w_mis_nxt;
`endif
    end
  end

  assign bus.pc          = r_pc;
  assign bus.pc_plus_inc = r_pc + ADDR_W'(INC);
  assign bus.pc_valid    = r_valid;
  assign bus.epc         = r_epc;
  assign bus.redirect    = r_redir;
`ifdef PC_ALIGN_CHK_EN
  assign bus.misalign    = r_mis;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: 32-bit and 8-bit instances.
// Reference model tracks the architectural PC rules every cycle.
module tb_pc_sequencer;

  logic clk;
  logic rst0;
  logic rst1;
  logic chk_en;
  int   n_vec;
  int   n_miss;

  pc_sequencer_if #(.ADDR_W(32)) b32 ();
  pc_sequencer_if #(.ADDR_W(8))  b8 ();

  pc_sequencer #(
    .ADDR_W    (32),
    .RESET_VEC (32'h100)
  ) u32 (
    .clk   (clk),
    .reset (rst0),
    .bus   (b32)
  );

  pc_sequencer #(
    .ADDR_W    (8),
    .RESET_VEC (8'hF0)
  ) u8 (
    .clk   (clk),
    .reset (rst1),
    .bus   (b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, index 0 = 32-bit DUT, 1 = 8-bit DUT
  logic [31:0] m_pc    [2];
  logic [31:0] m_epc   [2];
  bit          m_run   [2];
  bit          m_valid [2];
  bit          m_redir [2];
  bit          m_mis   [2];

  task automatic mreset(int k, logic [31:0] rv);
    m_pc[k]    = rv;
    m_epc[k]   = 0;
    m_run[k]   = 0;
    m_valid[k] = 0;
    m_redir[k] = 0;
    m_mis[k]   = 0;
  endtask

  task automatic step(
    int k, logic [31:0] mask, logic [31:0] ev_addr,
    bit hold, bit jv, logic [31:0] jt,
    bit br, logic [31:0] bt,
    bit ex, logic [31:0] ep, bit er
  );
    logic [31:0] tgt;
    bit has;
    if (!m_run[k]) begin
      m_run[k]   = 1;
      m_valid[k] = 1;
      m_redir[k] = 0;
      m_mis[k]   = 0;
      return;
    end
    m_redir[k] = 1;
    m_mis[k]   = 0;
    if (ex) begin
      m_pc[k]  = ev_addr & mask;
      m_epc[k] = ep & mask;
      return;
    end
    has = 1;
    if (er)      tgt = m_epc[k];
    else if (br) tgt = bt;
    else if (jv) tgt = jt;
    else begin
      has = 0;
      tgt = 0;
    end
    if (!has) begin
      m_redir[k] = 0;
      if (!hold) m_pc[k] = (m_pc[k] + 4) & mask;
      return;
    end
`ifdef PC_ALIGN_CHK_EN
    if (tgt % 4 != 0) begin
      m_pc[k]  = ev_addr & mask;
      m_epc[k] = tgt & mask;
      m_mis[k] = 1;
      return;
    end
`endif
    m_pc[k] = tgt & mask;
  endtask

  always @(posedge clk or negedge rst0) begin
    if (!rst0) mreset(0, 32'h100);
    else step(0, 32'hFFFF_FFFF, 32'h180,
              b32.hold_pc, b32.jump_valid,
              b32.jump_target, b32.branch_taken,
              b32.branch_target, b32.exc_valid,
              b32.exc_pc, b32.eret_valid);
  end

  always @(posedge clk or negedge rst1) begin
    if (!rst1) mreset(1, 32'hF0);
    else step(1, 32'hFF, 32'h180,
              b8.hold_pc, b8.jump_valid,
              {24'b0, b8.jump_target},
              b8.branch_taken,
              {24'b0, b8.branch_target},
              b8.exc_valid, {24'b0, b8.exc_pc},
              b8.eret_valid);
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m32.pc", b32.pc, m_pc[0]);
      chk("m32.ppi", b32.pc_plus_inc, m_pc[0] + 4);
      chk("m32.valid", 32'(b32.pc_valid), 32'(m_valid[0]));
      chk("m32.epc", b32.epc, m_epc[0]);
      chk("m32.redir", 32'(b32.redirect), 32'(m_redir[0]));
      chk("m8.pc", 32'(b8.pc), m_pc[1]);
      chk("m8.ppi", 32'(b8.pc_plus_inc), (m_pc[1] + 4) & 32'hFF);
      chk("m8.valid", 32'(b8.pc_valid), 32'(m_valid[1]));
      chk("m8.epc", 32'(b8.epc), m_epc[1]);
      chk("m8.redir", 32'(b8.redirect), 32'(m_redir[1]));
`ifdef PC_ALIGN_CHK_EN
      chk("m32.mis", 32'(b32.misalign), 32'(m_mis[0]));
      chk("m8.mis", 32'(b8.misalign), 32'(m_mis[1]));
`endif
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    chk_en = 0;
    rst0   = 1;
    rst1   = 1;
    b32.hold_pc = 0; b32.jump_valid = 0;
    b32.jump_target = 0; b32.branch_taken = 0;
    b32.branch_target = 0; b32.exc_valid = 0;
    b32.exc_pc = 0; b32.eret_valid = 0;
    b8.hold_pc = 0; b8.jump_valid = 0;
    b8.jump_target = 0; b8.branch_taken = 0;
    b8.branch_target = 0; b8.exc_valid = 0;
    b8.exc_pc = 0; b8.eret_valid = 0;
    #2;
    rst0 = 0;
    rst1 = 0;
    chk_en = 1;
    repeat (3) tick;
    chk("rst.pc", b32.pc, 32'h100);
    chk("rst.valid", 32'(b32.pc_valid), 0);
    rst0 = 1;
    rst1 = 1;
    tick;
    chk("rel.pc", b32.pc, 32'h100);
    chk("rel.valid", 32'(b32.pc_valid), 1);
    chk("rel.redir", 32'(b32.redirect), 0);
    chk("rel8.pc", 32'(b8.pc), 32'hF0);
    tick;
    chk("seq.pc", b32.pc, 32'h104);
    chk("seq.ppi", b32.pc_plus_inc, 32'h108);
    chk("seq8.pc", 32'(b8.pc), 32'hF4);
    b32.jump_valid = 1;
    b32.jump_target = 32'h200;
    tick;
    b32.jump_valid = 0;
    chk("jmp.pc", b32.pc, 32'h200);
    chk("jmp.redir", 32'(b32.redirect), 1);
    b32.hold_pc = 1;
    tick;
    chk("hold1.pc", b32.pc, 32'h200);
    chk("hold1.redir", 32'(b32.redirect), 0);
    chk("w8.pc", 32'(b8.pc), 32'hFC);
    tick;
    chk("hold2.pc", b32.pc, 32'h200);
    chk("wrap8.pc", 32'(b8.pc), 32'h00);
    chk("wrap8.ppi", 32'(b8.pc_plus_inc), 32'h04);
    b32.branch_taken = 1;
    b32.branch_target = 32'h400;
    tick;
    b32.branch_taken = 0;
    b32.hold_pc = 0;
    chk("brhold.pc", b32.pc, 32'h400);
    chk("brhold.redir", 32'(b32.redirect), 1);
    tick;
    chk("brnext.pc", b32.pc, 32'h404);
    chk("brnext.redir", 32'(b32.redirect), 0);
    b32.branch_taken = 1;
    b32.branch_target = 32'h500;
    b32.jump_valid = 1;
    b32.jump_target = 32'h600;
    tick;
    b32.branch_taken = 0;
    b32.jump_valid = 0;
    chk("brjmp.pc", b32.pc, 32'h500);
    b32.exc_valid = 1;
    b32.exc_pc = 32'h30C;
    tick;
    b32.exc_valid = 0;
    chk("exc.pc", b32.pc, 32'h180);
    chk("exc.epc", b32.epc, 32'h30C);
    chk("exc.redir", 32'(b32.redirect), 1);
    tick;
    chk("exc2.pc", b32.pc, 32'h184);
    b32.eret_valid = 1;
    tick;
    b32.eret_valid = 0;
    chk("eret.pc", b32.pc, 32'h30C);
    chk("eret.epc", b32.epc, 32'h30C);
    tick;
    chk("eret2.pc", b32.pc, 32'h310);
    b32.exc_valid = 1;
    b32.exc_pc = 32'h7A0;
    b32.eret_valid = 1;
    tick;
    b32.exc_valid = 0;
    b32.eret_valid = 0;
    chk("excer.pc", b32.pc, 32'h180);
    chk("excer.epc", b32.epc, 32'h7A0);
    b32.jump_valid = 1;
    b32.jump_target = 32'h402;
    tick;
    b32.jump_valid = 0;
`ifdef PC_ALIGN_CHK_EN
    chk("mis.pc", b32.pc, 32'h180);
    chk("mis.epc", b32.epc, 32'h402);
    chk("mis.flag", 32'(b32.misalign), 1);
    chk("mis.redir", 32'(b32.redirect), 1);
    tick;
    chk("mis2.flag", 32'(b32.misalign), 0);
    chk("mis2.pc", b32.pc, 32'h184);
`else
    chk("unal.pc", b32.pc, 32'h402);
    chk("unal.epc", b32.epc, 32'h7A0);
    tick;
    chk("unal2.pc", b32.pc, 32'h406);
`endif
    b8.exc_valid = 1;
    b8.exc_pc = 8'h34;
    tick;
    b8.exc_valid = 0;
    chk("exc8.pc", 32'(b8.pc), 32'h80);
    chk("exc8.epc", 32'(b8.epc), 32'h34);
    tick;
    #2;
    rst1 = 0;
    #1;
    chk("arst8.pc", 32'(b8.pc), 32'hF0);
    chk("arst8.valid", 32'(b8.pc_valid), 0);
    chk("arst8.epc", 32'(b8.epc), 0);
    tick;
    rst1 = 1;
    tick;
    chk("rel8b.pc", 32'(b8.pc), 32'hF0);
    chk("rel8b.valid", 32'(b8.pc_valid), 1);
    tick;
    chk("seq8b.pc", 32'(b8.pc), 32'hF4);
    repeat (3) tick;
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter stage for the pipelined MIPS core, sitting at the head of IF. It holds the fetch PC and selects the next PC from several sources: sequential increment, ID-stage jump, EX-stage branch, exception vector and exception return. It also supports hazard-unit stalls. It owns the EPC register and provides a fetch-valid qualifier so IF does not fetch while the core is in reset.

## Interface
- `ADDR_W`, 32: PC and target width; minimum 8.
- `RESET_VEC`, 0: first fetch address after reset.
- `EXC_VEC`, 32'h0000_0180: exception handler address, truncated to `ADDR_W`.
- `INC`, 4: sequential increment in bytes.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `hold_pc` in 1: stall from the hazard unit.
- `jump_valid` in 1: J/JAL/JR resolved in ID.
- `jump_target` in ADDR_W: jump destination.
- `branch_taken` in 1: taken branch resolved in EX.
- `branch_target` in ADDR_W: branch destination.
- `exc_valid` in 1: exception raised.
- `exc_pc` in ADDR_W: faulting instruction address, saved into EPC.
- `eret_valid` in 1: return from exception.
- `pc` out ADDR_W: current fetch address.
- `pc_plus_inc` out ADDR_W: `pc + INC`, combinational, for link writes.
- `pc_valid` out 1: `pc` is a real fetch address.
- `epc` out ADDR_W: saved exception PC.
- `redirect` out 1: registered; high for one cycle after any non-sequential update, so IF/ID can flush.
- `misalign` out 1: registered misaligned-target flag. Present only with `PC_ALIGN_CHK_EN`.

## Operation
- Two-state FSM: `S_RESET` → `S_RUN`.
  - In `S_RESET`: `pc = RESET_VEC`, `pc_valid = 0`.
  - The first rising edge after `reset` deasserts moves the FSM to `S_RUN` and sets `pc_valid = 1`. `pc` is not incremented on this edge, so `RESET_VEC` is the first address fetched.
- Next-PC selection in `S_RUN`, highest priority first:
  1. `exc_valid`: `pc ← EXC_VEC`, `epc ← exc_pc`.
  2. `eret_valid`: `pc ← epc`.
  3. `branch_taken`: `pc ← branch_target`.
  4. `jump_valid`: `pc ← jump_target`.
  5. `hold_pc`: `pc` holds.
  6. Otherwise: `pc ← pc + INC`.
- Redirects 1–4 override `hold_pc`. A flushed wrong-path instruction must not stall the correct path.
- Arithmetic: `pc + INC` is modulo 2^ADDR_W; wrap from all-ones to low addresses is silent.
- `redirect ← 1` on edges taking sources 1–4, otherwise 0.
- `epc` changes only on `exc_valid`.
- `exc_valid` together with `eret_valid` on the same edge: the exception wins and `epc` is overwritten.
- `reset` asserted mid-operation, at any time: immediately (asynchronously) sets `pc = RESET_VEC`, `epc = 0`, `pc_valid = 0`, `redirect = 0`, `misalign = 0`, FSM = `S_RESET`.

## Timing
- `pc` is a register; a redirect input sampled at edge N appears on `pc` after edge N.
- Branch-redirect penalty visible to IF is therefore 1 cycle from EX resolution. `redirect` is asserted in the same cycle as the new `pc`.
- `pc_plus_inc` is combinational from `pc`; zero latency.
- `hold_pc` held for k cycles keeps `pc` constant for k cycles; there is no internal timeout.
- All inputs are ignored in `S_RESET` and on the release edge.

## Configuration
- `PC_ALIGN_CHK_EN` defined:
  - A branch, jump or eret target whose low two bits are non-zero is not loaded. Instead `pc ← EXC_VEC` and `epc ← offending target`.
  - `misalign` pulses high for one cycle, in the same cycle as the new `pc`; `redirect` also pulses.
  - An `exc_valid` on the same edge still wins, and `misalign` stays 0.
- Not defined: targets are loaded unchecked, the `misalign` port is absent, and no alignment logic is synthesised.

## Structure
- `pc_pkg`:
  - FSM state enum (`S_RESET`, `S_RUN`).
  - Next-PC source enum (`SRC_EXC`, `SRC_ERET`, `SRC_BR`, `SRC_JMP`, `SRC_HOLD`, `SRC_SEQ`).
  - Default `EXC_VEC` constant.
- One sub-module, `pc_next_sel`: combinational priority encoder producing the source enum and the next-PC value. The registers, FSM, EPC and the alignment check live in the top.

## Test plan
- Reset sequence: reset low for 3 cycles, then release; `RESET_VEC = 0x100` → `pc_valid` rises one edge after release with `pc = 0x100`; the next edge gives `pc = 0x104`.
- Stall versus branch: `hold_pc = 1` for 2 cycles at `pc = 0x200` → `pc` stays `0x200`; then `hold_pc = 1` with `branch_taken = 1`, target `0x400` → `pc = 0x400`, `redirect = 1` for one cycle.
- Branch versus jump on the same edge: branch `0x500`, jump `0x600` → `pc = 0x500`.
- Exception and return:
  - `exc_valid` with `exc_pc = 0x30C` → `pc = 0x180`, `epc = 0x30C`.
  - Later `eret_valid` → `pc = 0x30C`.
  - `exc_valid` together with `eret_valid` → `pc = 0x180`, `epc` updated.
- Wrap and mid-run reset: `ADDR_W = 8`, `pc = 0xFC` → next `pc = 0x00`. Assert reset asynchronously mid-cycle → `pc = RESET_VEC` and `pc_valid = 0` without waiting for a clock edge.
- With `PC_ALIGN_CHK_EN`: jump target `0x402` → `pc = 0x180`, `epc = 0x402`, `misalign` high for one cycle.
